// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared opcode, ALU-op and mul/div FSM encodings for the execute stage
package riscv_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL,
        ALU_SRA, ALU_OR, ALU_AND, ALU_LUI, ALU_AUIPC, ALU_PC4
    } alu_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

endpackage

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - iterative RV32M unit: shift-add multiply, restoring divide, 1 bit/cycle
module muldiv_iter
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [2:0]  func3_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] result_o
);

    md_state_e   state_q;
    logic [4:0]  count_q;
    logic [63:0] acc_q;
    logic [31:0] opnd_q;
    logic [2:0]  f3_q;
    logic        neg_q;

    logic        a_sgn, b_sgn, is_div, neg_d;
    logic [31:0] a_mag, b_mag;
    logic [32:0] mul_sum, div_shift;
    logic [31:0] div_diff;
    logic        div_ge;
    logic [63:0] step_d, prod_fix;
    logic [31:0] quo_fix, rem_fix;

    // MULHSU/MULHU/DIVU/REMU treat one or both operands as unsigned
    assign is_div = func3_i[2];
    assign a_sgn  = a_i[31] & (func3_i[2] ? ~func3_i[0] : ~(func3_i[1] & func3_i[0]));
    assign b_sgn  = b_i[31] & (func3_i[2] ? ~func3_i[0] : ~func3_i[1]);
    assign a_mag  = a_sgn ? -a_i : a_i;
    assign b_mag  = b_sgn ? -b_i : b_i;
    // Divide by zero keeps the all-ones quotient unsigned; remainder follows the dividend
    assign neg_d  = is_div ? (func3_i[1] ? a_sgn : ((a_sgn ^ b_sgn) & (b_i != 32'd0)))
                           : (a_sgn ^ b_sgn);

    assign mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    assign div_shift = {acc_q[63:32], acc_q[31]};
    assign div_ge    = div_shift >= {1'b0, opnd_q};
    assign div_diff  = div_shift[31:0] - opnd_q;
    assign step_d    = f3_q[2] ? {(div_ge ? div_diff : div_shift[31:0]), acc_q[30:0], div_ge}
                               : {mul_sum, acc_q[31:1]};

    assign prod_fix = neg_q ? -acc_q : acc_q;
    assign quo_fix  = neg_q ? -acc_q[31:0] : acc_q[31:0];
    assign rem_fix  = neg_q ? -acc_q[63:32] : acc_q[63:32];

    assign result_o = f3_q[2] ? (f3_q[1] ? rem_fix : quo_fix)
                              : ((f3_q[1:0] == 2'b00) ? prod_fix[31:0] : prod_fix[63:32]);
    assign done_o   = (state_q == MD_DONE);
    assign stall_o  = rst_n & (((state_q == MD_IDLE) & start_i) | (state_q == MD_BUSY));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MD_IDLE;
            count_q <= 5'd0;
            acc_q   <= 64'd0;
            opnd_q  <= 32'd0;
            f3_q    <= 3'd0;
            neg_q   <= 1'b0;
        end else begin
            case (state_q)
                MD_IDLE: if (start_i) begin
                    state_q <= MD_BUSY;
                    count_q <= 5'd0;
                    f3_q    <= func3_i;
                    neg_q   <= neg_d;
                    opnd_q  <= is_div ? b_mag : a_mag;
                    acc_q   <= {32'd0, (is_div ? a_mag : b_mag)};
                end
                MD_BUSY: begin
                    acc_q <= step_d;
                    if (count_q == 5'd31) state_q <= MD_DONE;
                    else                  count_q <= count_q + 5'd1;
                end
                MD_DONE: begin
                    state_q <= MD_IDLE;
                    count_q <= 5'd0;
                end
                default: state_q <= MD_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: ALU, branch resolution, RV32M unit and EX/MEM register
module ex_stage
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_in,
    input  logic [6:0]  opcode,
    input  logic [2:0]  func3,
    input  logic [6:0]  func7,
    input  logic [31:0] imm,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [4:0]  rd,
    input  logic        ALUsrc,
    input  logic        Branch,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        RegWrite,
    input  logic        MemToReg,
    output logic        branch_taken,
    output logic [31:0] branch_target,
    output logic        stall,
    output logic [31:0] alu_result_out,
    output logic [31:0] store_data_out,
    output logic [4:0]  rd_out,
    output logic        MemRead_out,
    output logic        MemWrite_out,
    output logic        RegWrite_out,
    output logic        MemToReg_out
);

    alu_op_e     alu_op;
    logic [31:0] opb, alu_res, md_result;
    logic [4:0]  shamt;
    logic        m_op, md_done, is_jal, is_jalr, cond;

    assign opb     = ALUsrc ? imm : op_b;
    assign shamt   = opb[4:0];
    assign m_op    = (opcode == OPC_OP) && (func7 == F7_MULDIV);
    assign is_jal  = (opcode == OPC_JAL);
    assign is_jalr = (opcode == OPC_JALR);

    always_comb begin
        alu_op = ALU_ADD;
        if (opcode == OPC_LUI)          alu_op = ALU_LUI;
        else if (opcode == OPC_AUIPC)   alu_op = ALU_AUIPC;
        else if (is_jal || is_jalr)     alu_op = ALU_PC4;
        else if (opcode == OPC_OP || opcode == OPC_OP_IMM) begin
            case (func3)
                3'b000: alu_op = (opcode == OPC_OP && func7[5]) ? ALU_SUB : ALU_ADD;
                3'b001: alu_op = ALU_SLL;
                3'b010: alu_op = ALU_SLT;
                3'b011: alu_op = ALU_SLTU;
                3'b100: alu_op = ALU_XOR;
                3'b101: alu_op = func7[5] ? ALU_SRA : ALU_SRL;
                3'b110: alu_op = ALU_OR;
                default: alu_op = ALU_AND;
            endcase
        end
    end

    always_comb begin
        alu_res = 32'd0;
        case (alu_op)
            ALU_ADD:   alu_res = op_a + opb;
            ALU_SUB:   alu_res = op_a - opb;
            ALU_SLL:   alu_res = op_a << shamt;
            ALU_SLT:   alu_res = {31'd0, $signed(op_a) < $signed(opb)};
            ALU_SLTU:  alu_res = {31'd0, op_a < opb};
            ALU_XOR:   alu_res = op_a ^ opb;
            ALU_SRL:   alu_res = op_a >> shamt;
            ALU_SRA:   alu_res = $signed(op_a) >>> shamt;
            ALU_OR:    alu_res = op_a | opb;
            ALU_AND:   alu_res = op_a & opb;
            ALU_LUI:   alu_res = imm;
            ALU_AUIPC: alu_res = pc_in + imm;
            ALU_PC4:   alu_res = pc_in + 32'd4;
            default:   alu_res = 32'd0;
        endcase
    end

    always_comb begin
        cond = 1'b0;
        case (func3)
            3'b000: cond = (op_a == op_b);
            3'b001: cond = (op_a != op_b);
            3'b100: cond = $signed(op_a) < $signed(op_b);
            3'b101: cond = $signed(op_a) >= $signed(op_b);
            3'b110: cond = op_a < op_b;
            3'b111: cond = op_a >= op_b;
            default: cond = 1'b0;
        endcase
    end

    assign branch_taken  = ((Branch & cond) | is_jal | is_jalr) & ~stall;
    assign branch_target = is_jalr ? ((op_a + imm) & ~32'd1) : (pc_in + imm);

    muldiv_iter u_muldiv (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (m_op),
        .func3_i  (func3),
        .a_i      (op_a),
        .b_i      (op_b),
        .stall_o  (stall),
        .done_o   (md_done),
        .result_o (md_result)
    );

    // A stalled cycle writes a bubble so nothing downstream commits twice
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || stall) begin
            alu_result_out <= 32'd0;
            store_data_out <= 32'd0;
            rd_out         <= 5'd0;
            MemRead_out    <= 1'b0;
            MemWrite_out   <= 1'b0;
            RegWrite_out   <= 1'b0;
            MemToReg_out   <= 1'b0;
        end else begin
            alu_result_out <= md_done ? md_result : alu_res;
            store_data_out <= op_b;
            rd_out         <= rd;
            MemRead_out    <= MemRead;
            MemWrite_out   <= MemWrite;
            RegWrite_out   <= RegWrite;
            MemToReg_out   <= MemToReg;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - scoreboard bench for ex_stage with directed vectors
module tb_ex_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_in = '0, imm = '0, op_a = '0, op_b = '0;
    logic [6:0]  opcode = '0, func7 = '0;
    logic [2:0]  func3 = '0;
    logic [4:0]  rd = '0;
    logic        ALUsrc = 0, Branch = 0, MemRead = 0, MemWrite = 0, RegWrite = 0, MemToReg = 0;
    logic        branch_taken, stall;
    logic [31:0] branch_target, alu_result_out, store_data_out;
    logic [4:0]  rd_out;
    logic        MemRead_out, MemWrite_out, RegWrite_out, MemToReg_out;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic [31:0] store;
        logic [4:0]  rd;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   rd_next = 1;
    bit   done = 0;

    ex_stage dut (
        .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .opcode(opcode), .func3(func3),
        .func7(func7), .imm(imm), .op_a(op_a), .op_b(op_b), .rd(rd), .ALUsrc(ALUsrc),
        .Branch(Branch), .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .MemToReg(MemToReg), .branch_taken(branch_taken), .branch_target(branch_target),
        .stall(stall), .alu_result_out(alu_result_out), .store_data_out(store_data_out),
        .rd_out(rd_out), .MemRead_out(MemRead_out), .MemWrite_out(MemWrite_out),
        .RegWrite_out(RegWrite_out), .MemToReg_out(MemToReg_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic issue(input string nm, input logic [6:0] opc, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im, input logic [31:0] pc, input logic src,
                         input logic br, input logic rw, input logic [31:0] exp_res,
                         input int exp_stall, input logic exp_tk, input logic [31:0] exp_tgt);
        exp_t e;
        int   cnt, bub;
        @(negedge clk);
        opcode = opc; func3 = f3; func7 = f7; op_a = a; op_b = b; imm = im; pc_in = pc;
        ALUsrc = src; Branch = br; RegWrite = rw; rd = rd_next[4:0];
        if (rw) begin
            e.name = nm; e.res = exp_res; e.store = b; e.rd = rd_next[4:0];
            exp_q.push_back(e);
        end
        rd_next = (rd_next % 31) + 1;
        #1;
        chk({nm, "_taken"}, {31'd0, branch_taken}, {31'd0, exp_tk});
        if (exp_tk) chk({nm, "_target"}, branch_target, exp_tgt);
        cnt = 0; bub = 0;
        while (stall && cnt < 100) begin
            cnt++;
            @(posedge clk); @(negedge clk); #1;
            if (RegWrite_out || MemRead_out || MemWrite_out) bub++;
        end
        chk({nm, "_stall_cycles"}, 32'(cnt), 32'(exp_stall));
        if (exp_stall > 0) chk({nm, "_bubble"}, 32'(bub), 32'd0);
        @(posedge clk);
    endtask

    // Monitor: every committed write in EX/MEM must match the oldest expectation
    initial begin
        exp_t e;
        while (!done) begin
            @(negedge clk);
            if (rst_n && RegWrite_out) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_commit", alu_result_out, 32'hxxxxxxxx);
                end else begin
                    e = exp_q.pop_front();
                    chk({e.name, "_result"}, alu_result_out, e.res);
                    chk({e.name, "_store"}, store_data_out, e.store);
                    chk({e.name, "_rd"}, {27'd0, rd_out}, {27'd0, e.rd});
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_alu", alu_result_out, 32'd0);
        chk("reset_ctrl", {28'd0, RegWrite_out, MemRead_out, MemWrite_out, MemToReg_out}, 32'd0);
        chk("reset_stall", {31'd0, stall}, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        //    name      opc         f3 f7     a             b             imm           pc         src br rw exp           stl tk tgt
        issue("add",    OPC_OP,     0, 7'h00, 32'd5,        32'hFFFFFFFD, 32'd0,        32'd0,     0, 0, 1, 32'd2,        0, 0, 0);
        issue("sub",    OPC_OP,     0, 7'h20, 32'd10,       32'd3,        32'd0,        32'd0,     0, 0, 1, 32'd7,        0, 0, 0);
        issue("addi",   OPC_OP_IMM, 0, 7'h00, 32'h10,       32'hDEAD,     32'hFFFFFFFF, 32'd0,     1, 0, 1, 32'hF,        0, 0, 0);
        issue("srai",   OPC_OP_IMM, 5, 7'h20, 32'h80000000, 32'd0,        32'd4,        32'd0,     1, 0, 1, 32'hF8000000, 0, 0, 0);
        issue("srl",    OPC_OP,     5, 7'h00, 32'h80000000, 32'd4,        32'd0,        32'd0,     0, 0, 1, 32'h08000000, 0, 0, 0);
        issue("sll",    OPC_OP,     1, 7'h00, 32'd1,        32'h21,       32'd0,        32'd0,     0, 0, 1, 32'd2,        0, 0, 0);
        issue("slt",    OPC_OP,     2, 7'h00, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,     0, 0, 1, 32'd1,        0, 0, 0);
        issue("sltu",   OPC_OP,     3, 7'h00, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,     0, 0, 1, 32'd0,        0, 0, 0);
        issue("xor",    OPC_OP,     4, 7'h00, 32'hF0F0,     32'hFF00,     32'd0,        32'd0,     0, 0, 1, 32'h0FF0,     0, 0, 0);
        issue("and",    OPC_OP,     7, 7'h00, 32'hF0F0,     32'hFF00,     32'd0,        32'd0,     0, 0, 1, 32'hF000,     0, 0, 0);
        issue("lui",    OPC_LUI,    0, 7'h00, 32'd9,        32'd0,        32'h12345000, 32'd0,     1, 0, 1, 32'h12345000, 0, 0, 0);
        issue("auipc",  OPC_AUIPC,  0, 7'h00, 32'd0,        32'd0,        32'h1000,     32'h100,   1, 0, 1, 32'h1100,     0, 0, 0);
        issue("blt",    OPC_BRANCH, 4, 7'h00, 32'hFFFFFFFF, 32'd1,        32'h20,       32'h100,   0, 1, 0, 32'd0,        0, 1, 32'h120);
        issue("bltu",   OPC_BRANCH, 6, 7'h00, 32'hFFFFFFFF, 32'd1,        32'h20,       32'h100,   0, 1, 0, 32'd0,        0, 0, 0);
        issue("beq",    OPC_BRANCH, 0, 7'h00, 32'd5,        32'd5,        32'hFFFFFFF0, 32'h200,   0, 1, 0, 32'd0,        0, 1, 32'h1F0);
        issue("jal",    OPC_JAL,    0, 7'h00, 32'd0,        32'd0,        32'h10,       32'h400,   1, 0, 1, 32'h404,      0, 1, 32'h410);
        issue("jalr",   OPC_JALR,   0, 7'h00, 32'h203,      32'd0,        32'd0,        32'h300,   1, 0, 1, 32'h304,      0, 1, 32'h202);
        issue("mul",    OPC_OP,     0, 7'h01, 32'h10000,    32'h10000,    32'd0,        32'd0,     0, 0, 1, 32'd0,       33, 0, 0);
        issue("mulhu",  OPC_OP,     3, 7'h01, 32'h10000,    32'h10000,    32'd0,        32'd0,     0, 0, 1, 32'd1,       33, 0, 0);
        issue("mul_neg",OPC_OP,     0, 7'h01, 32'hFFFFFFFD, 32'd5,        32'd0,        32'd0,     0, 0, 1, 32'hFFFFFFF1,33, 0, 0);
        issue("mulh",   OPC_OP,     1, 7'h01, 32'hFFFFFFFF, 32'd2,        32'd0,        32'd0,     0, 0, 1, 32'hFFFFFFFF,33, 0, 0);
        issue("mulhsu", OPC_OP,     2, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd0,     0, 0, 1, 32'hFFFFFFFF,33, 0, 0);
        issue("div_ovf",OPC_OP,     4, 7'h01, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'd0,     0, 0, 1, 32'h80000000,33, 0, 0);
        issue("rem_ovf",OPC_OP,     6, 7'h01, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'd0,     0, 0, 1, 32'd0,       33, 0, 0);
        issue("divu_z", OPC_OP,     5, 7'h01, 32'd7,        32'd0,        32'd0,        32'd0,     0, 0, 1, 32'hFFFFFFFF,33, 0, 0);
        issue("remu_z", OPC_OP,     7, 7'h01, 32'd7,        32'd0,        32'd0,        32'd0,     0, 0, 1, 32'd7,       33, 0, 0);
        issue("div_neg",OPC_OP,     4, 7'h01, 32'hFFFFFFF9, 32'd2,        32'd0,        32'd0,     0, 0, 1, 32'hFFFFFFFD,33, 0, 0);
        issue("rem_neg",OPC_OP,     6, 7'h01, 32'hFFFFFFF9, 32'd2,        32'd0,        32'd0,     0, 0, 1, 32'hFFFFFFFF,33, 0, 0);
        issue("div_z",  OPC_OP,     4, 7'h01, 32'd7,        32'd0,        32'd0,        32'd0,     0, 0, 1, 32'hFFFFFFFF,33, 0, 0);
        issue("rem_z",  OPC_OP,     6, 7'h01, 32'hFFFFFFF9, 32'd0,        32'd0,        32'd0,     0, 0, 1, 32'hFFFFFFF9,33, 0, 0);

        // Reset while the divider is at BUSY count 10; the operation must never commit
        @(negedge clk);
        opcode = OPC_OP; func3 = 3'd5; func7 = F7_MULDIV; op_a = 32'd100; op_b = 32'd7;
        ALUsrc = 0; Branch = 0; RegWrite = 1; rd = 5'd9;
        repeat (11) @(posedge clk);
        #1;
        chk("midop_stall_before", {31'd0, stall}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midop_stall", {31'd0, stall}, 32'd0);
        chk("midop_alu", alu_result_out, 32'd0);
        chk("midop_outs", {store_data_out[26:0], rd_out}, 32'd0);
        chk("midop_ctrl", {28'd0, RegWrite_out, MemRead_out, MemWrite_out, MemToReg_out}, 32'd0);
        opcode = 7'd0; func7 = 7'd0; RegWrite = 0;
        @(negedge clk); rst_n = 1'b1;

        issue("add_post",OPC_OP,    0, 7'h00, 32'h7FFFFFFF, 32'd1,        32'd0,        32'd0,     0, 0, 1, 32'h80000000, 0, 0, 0);
        issue("add_wrap",OPC_OP,    0, 7'h00, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,     0, 0, 1, 32'd0,        0, 0, 0);

        @(negedge clk);
        RegWrite = 0; opcode = 7'd0;
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        done = 1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: single pipeline clock, all state on rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have inputs pc_in[31:0], opcode[6:0], func3[2:0], func7[6:0] and imm[31:0]: decoded fields from the ID/EX register.
REQ-004 SHALL have inputs op_a[31:0] and op_b[31:0]: rs1 and rs2 values, already forwarded upstream.
REQ-005 SHALL have inputs rd[4:0] and the control bits ALUsrc, Branch, MemRead, MemWrite, RegWrite, MemToReg.
REQ-006 SHALL have outputs branch_taken (1 bit) and branch_target[31:0]: combinational, to IF and the hazard unit.
REQ-007 SHALL have output stall (1 bit): combinational busy; IF/ID and ID/EX hold while it is high.
REQ-008 SHALL have registered outputs alu_result_out[31:0], store_data_out[31:0] and rd_out[4:0].
REQ-009 SHALL have registered outputs MemRead_out, MemWrite_out, RegWrite_out, MemToReg_out (EX/MEM register).

Function
REQ-010 SHALL compute operand B as imm when ALUsrc=1, else op_b.
REQ-011 SHALL support ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, LUI (imm) and AUIPC (pc_in+imm).
REQ-012 SHALL select SUB only for R-type (opcode 0110011) with func7[5]=1; SRA/SRAI on func7[5]=1; shift amount = operand B[4:0].
REQ-013 SHALL wrap all arithmetic modulo 2^32 with no overflow flag.
REQ-014 SHALL resolve BEQ, BNE, BLT, BGE, BLTU, BGEU when Branch=1, comparing op_a with op_b.
REQ-015 SHALL set branch_target: pc_in+imm for branches and JAL; (op_a+imm) with bit0 cleared for JALR.
REQ-016 SHALL hold branch_taken high for a true branch condition, JAL or JALR, and low when stall=1.
REQ-017 SHALL produce alu_result = pc_in+4 for JAL/JALR.
REQ-018 SHALL execute RV32M (opcode 0110011, func7=0000001) in an iterative unit: MUL/MULH/MULHSU/MULHU by shift-add, DIV/DIVU/REM/REMU by restoring division, 1 bit per cycle.
REQ-019 SHALL run the unit FSM IDLE -> BUSY -> DONE -> IDLE.
REQ-020 SHALL leave IDLE for BUSY when an M-op is present, loading operands (magnitudes plus sign flags) and count=0.
REQ-021 SHALL iterate in BUSY for 32 cycles (count 0..31) and enter DONE after count 31.
REQ-022 SHALL in DONE apply sign correction, load the result into EX/MEM and return to IDLE.
REQ-023 SHALL hold stall=1 in the IDLE arrival cycle and in all BUSY cycles, and stall=0 in DONE: 33 stall cycles, result in EX/MEM at the 34th edge.
REQ-024 SHALL load a bubble into EX/MEM on every edge while stall=1: RegWrite_out, MemRead_out, MemWrite_out all 0.
REQ-025 SHALL on divide by zero give quotient 0xFFFFFFFF and remainder = dividend, with no early exit.
REQ-026 SHALL on DIV/REM of 0x80000000 by -1 give quotient 0x80000000 and remainder 0.
REQ-027 SHALL register non-M ops into EX/MEM one edge after presentation (latency 1, no stall).
REQ-028 SHALL pass op_b unchanged to store_data_out.

Reset
REQ-029 SHALL on rst_n=0 immediately zero all registered outputs, with FSM = IDLE and count=0.
REQ-030 SHALL when reset occurs mid-BUSY abandon the operation, deassert stall, and commit no result.

Structure
REQ-031 SHALL put the ALU op encoding, FSM state encoding, opcode constants (OP, OP_IMM, BRANCH, JAL, JALR, LUI, AUIPC) and M-op func7 constant in shared package riscv_pkg.
REQ-032 SHALL place the multiply/divide FSM and datapath in sub-module muldiv_iter; ALU, branch logic and EX/MEM register stay in ex_stage.

Verification
REQ-033 SHALL check ADD: op_a=5, op_b=0xFFFFFFFD -> alu_result_out=2 one edge later, stall never high.
REQ-034 SHALL check BLT: op_a=0xFFFFFFFF, op_b=1, pc_in=0x100, imm=0x20 -> branch_taken=1, branch_target=0x120; BLTU with the same operands -> branch_taken=0.
REQ-035 SHALL check MUL: 0x00010000 x 0x00010000 -> MUL result 0, MULHU result 1; stall high exactly 33 cycles; bubble seen in EX/MEM during the stall.
REQ-036 SHALL check DIV: 0x80000000 by 0xFFFFFFFF -> 0x80000000; DIVU 7/0 -> 0xFFFFFFFF; REMU 7/0 -> 7.
REQ-037 SHALL check reset mid-operation: rst_n low at BUSY count 10 -> stall=0 and all outputs 0 immediately; a following ADD completes normally.
REQ-038 SHALL check JALR: op_a=0x203, imm=0 -> branch_target=0x202, alu_result_out=pc_in+4.
